// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler.
package fft_sched_pkg;

    localparam int unsigned BYTES_PER_BIN = 6;
    localparam int unsigned SMP_W         = 24;

    // Frame-level states. The top parks in StTxByte while the serializer runs
    // its own byte/hold/wait handshake for the current bin.
    typedef enum logic [2:0] {
        StFill,
        StStart,
        StCompute,
        StRdReq,
        StRdLat,
        StTxByte,
        StTxHold,
        StTxWait
    } state_e;

    // Per-byte handshake phases inside the serializer.
    typedef enum logic [1:0] {
        SerIdle,
        SerByte,
        SerHold,
        SerWait
    } ser_state_e;

endpackage

// File: rtl/fft_bin_serializer.sv
// Serializes one FFT bin (Re then Im, MSB first) into six UART bytes.
module fft_bin_serializer
    import fft_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [SMP_W-1:0] re_i,
    input  logic [SMP_W-1:0] im_i,
    input  logic             tx_busy_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_start_o,
    output logic             done_o
);

    localparam int unsigned SREG_W   = 2 * SMP_W;
    localparam logic [2:0]  LastByte = 3'(BYTES_PER_BIN - 1);

    ser_state_e        phase_q, phase_d;
    logic [SREG_W-1:0] sreg_q, sreg_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        tx_data_q, tx_data_d;

    // Byte handshake: start when TX idle, hold one cycle for busy to rise, then wait it out.
    always_comb begin
        phase_d    = phase_q;
        sreg_d     = sreg_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_start_o = 1'b0;
        done_o     = 1'b0;
        if (!rst_i) begin
            unique case (phase_q)
                SerIdle: begin
                    if (load_i) begin
                        sreg_d  = {re_i, im_i};
                        idx_d   = '0;
                        phase_d = SerByte;
                    end
                end
                SerByte: begin
                    if (!tx_busy_i) begin
                        tx_start_o = 1'b1;
                        tx_data_d  = sreg_q[SREG_W-1 -: 8];
                        phase_d    = SerHold;
                    end
                end
                SerHold: begin
                    sreg_d  = {sreg_q[SREG_W-9:0], 8'h00};
                    phase_d = SerWait;
                end
                SerWait: begin
                    if (!tx_busy_i) begin
                        if (idx_q < LastByte) begin
                            idx_d   = idx_q + 3'd1;
                            phase_d = SerByte;
                        end else begin
                            done_o  = 1'b1;
                            phase_d = SerIdle;
                        end
                    end
                end
                default: phase_d = SerIdle;
            endcase
        end
        // Present the new byte in its start cycle, otherwise hold the last one sent.
        tx_data_o = tx_start_o ? sreg_q[SREG_W-1 -: 8] : tx_data_q;
    end

    // Serializer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q   <= SerIdle;
            sreg_q    <= '0;
            idx_q     <= '0;
            tx_data_q <= '0;
        end else begin
            phase_q   <= phase_d;
            sreg_q    <= sreg_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
        end
    end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler: fills the FFT input buffer, kicks the FFT, drains results to UART.
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int unsigned N_POINT = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned GAP_CYC = 52070
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smp_en_i,
    input  logic [DATA_W-1:0] smp_re_i,
    input  logic [DATA_W-1:0] smp_im_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_re_o,
    output logic [DATA_W-1:0] wr_im_o,
    output logic              fft_start_o,
    input  logic              fft_done_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_re_i,
    input  logic [DATA_W-1:0] rd_im_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic              busy_o,
    output logic              drop_o,
    output logic              gap_err_o
);

    localparam int unsigned       GAP_W   = $clog2(GAP_CYC + 1);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_POINT - 1);
    localparam logic [GAP_W-1:0]  GapLast = GAP_W'(GAP_CYC - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              ser_load;
    logic              ser_done;

    // Frame FSM, sample counter and inter-sample gap timer.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        bin_d       = bin_q;
        gap_d       = gap_q;
        wr_en_o     = 1'b0;
        fft_start_o = 1'b0;
        drop_o      = 1'b0;
        gap_err_o   = 1'b0;
        ser_load    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFill: begin
                    // A strobe in the timeout cycle wins over the timeout.
                    if (smp_en_i) begin
                        wr_en_o = 1'b1;
                        gap_d   = '0;
                        if (wr_cnt_q == LastIdx) begin
                            wr_cnt_d = '0;
                            state_d  = StStart;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end else if (wr_cnt_q != '0) begin
                        if (gap_q == GapLast) begin
                            wr_cnt_d  = '0;
                            gap_d     = '0;
                            gap_err_o = 1'b1;
                        end else begin
                            gap_d = gap_q + 1'b1;
                        end
                    end
                end
                StStart: begin
                    fft_start_o = 1'b1;
                    state_d     = StCompute;
                end
                StCompute: begin
                    if (fft_done_i) begin
                        bin_d   = '0;
                        state_d = StRdReq;
                    end
                end
                StRdReq: state_d = StRdLat;
                StRdLat: begin
                    ser_load = 1'b1;
                    state_d  = StTxByte;
                end
                StTxByte: begin
                    if (ser_done) begin
                        if (bin_q == LastIdx) begin
                            state_d = StFill;
                        end else begin
                            bin_d   = bin_q + 1'b1;
                            state_d = StRdReq;
                        end
                    end
                end
                default: state_d = StFill;
            endcase
            drop_o = smp_en_i && (state_q != StFill);
        end
    end

    // Datapath outputs that follow the registered state directly.
    always_comb begin
        busy_o    = (state_q != StFill);
        wr_addr_o = wr_cnt_q;
        rd_addr_o = bin_q;
        wr_re_o   = wr_en_o ? smp_re_i : '0;
        wr_im_o   = wr_en_o ? smp_im_i : '0;
    end

    // Frame state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFill;
            wr_cnt_q <= '0;
            bin_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            bin_q    <= bin_d;
            gap_q    <= gap_d;
        end
    end

    fft_bin_serializer u_ser (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (ser_load),
        .re_i       (rd_re_i),
        .im_i       (rd_im_i),
        .tx_busy_i  (tx_busy_i),
        .tx_data_o  (tx_data_o),
        .tx_start_o (tx_start_o),
        .done_o     (ser_done)
    );

endmodule
